// File: rtl/delay_line_pkg.sv
// Shared types and arithmetic helpers for the multi-channel delay line.
package delay_line_pkg;

  typedef enum logic {
    MODE_DELAY = 1'b0,
    MODE_ECHO  = 1'b1
  } mode_e;

  // Signed add clamped to the range of a two's complement number of 'width' bits (width <= 31).
  function automatic int sat_add(input int a, input int b, input int width);
    int sum;
    int max_v;
    int min_v;
    sum   = a + b;
    max_v = (1 <<< (width - 1)) - 1;
    min_v = -(1 <<< (width - 1));
    if (sum > max_v) begin
      return max_v;
    end
    if (sum < min_v) begin
      return min_v;
    end
    return sum;
  endfunction

endpackage

// File: rtl/dp_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
module dp_ram #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  // NOTE: the array has no reset so it maps onto block RAM; stale contents are masked by the fill counters.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/multi_ch_delay_line.sv
// Multi-channel delay line: per-channel circular regions of one shared RAM, programmable delay and echo mix.
module multi_ch_delay_line
  import delay_line_pkg::*;
#(
  parameter int ADDR_WIDTH = 9,
  parameter int D_WIDTH    = 8,
  parameter int NUM_CH     = 2,
  parameter int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [CH_W-1:0]       in_ch,
  input  logic [D_WIDTH-1:0]    in_data,
  input  logic                  cfg_we,
  input  logic [CH_W-1:0]       cfg_ch,
  input  logic [ADDR_WIDTH-1:0] cfg_delay,
  input  logic                  cfg_mode,
  output logic                  out_valid,
  output logic [CH_W-1:0]       out_ch,
  output logic [D_WIDTH-1:0]    out_data
);

  localparam int RAM_AW    = CH_W + ADDR_WIDTH;
  localparam int RAM_DEPTH = NUM_CH * (2 ** ADDR_WIDTH);

  logic [ADDR_WIDTH-1:0] wp_q    [NUM_CH];
  logic [ADDR_WIDTH-1:0] wp_d    [NUM_CH];
  logic [ADDR_WIDTH-1:0] fill_q  [NUM_CH];
  logic [ADDR_WIDTH-1:0] fill_d  [NUM_CH];
  logic [ADDR_WIDTH-1:0] delay_q [NUM_CH];
  logic [ADDR_WIDTH-1:0] delay_d [NUM_CH];
  mode_e                 mode_q  [NUM_CH];
  mode_e                 mode_d  [NUM_CH];

  logic                  in_ok;
  logic                  cfg_ok;
  logic [ADDR_WIDTH-1:0] cur_wp;
  logic [ADDR_WIDTH-1:0] cur_fill;
  logic [ADDR_WIDTH-1:0] cur_delay;
  mode_e                 cur_mode;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [D_WIDTH-1:0]    ram_rdata;

  logic                      s1_valid_q, s1_valid_d;
  logic [CH_W-1:0]           s1_ch_q, s1_ch_d;
  logic signed [D_WIDTH-1:0] s1_data_q, s1_data_d;
  mode_e                     s1_mode_q, s1_mode_d;
  logic                      s1_bypass_q, s1_bypass_d;
  logic                      s1_prime_q, s1_prime_d;

  logic signed [D_WIDTH-1:0] delayed;
  logic [D_WIDTH-1:0]        mixed;
  logic                      out_valid_q, out_valid_d;
  logic [CH_W-1:0]           out_ch_q, out_ch_d;
  logic [D_WIDTH-1:0]        out_data_q, out_data_d;

  // Widened compare keeps the range check meaningful when NUM_CH is not a power of two.
  assign in_ok  = in_valid && ({1'b0, in_ch} < (CH_W + 1)'(NUM_CH));
  assign cfg_ok = cfg_we && ({1'b0, cfg_ch} < (CH_W + 1)'(NUM_CH));

  // NOTE: every always_comb output gets a default first so no latch is inferred on idle paths.
  always_comb begin
    cur_wp    = wp_q[in_ch];
    cur_fill  = fill_q[in_ch];
    cur_delay = delay_q[in_ch];
    cur_mode  = mode_q[in_ch];
    rd_ptr    = cur_wp - cur_delay;

    wp_d    = wp_q;
    fill_d  = fill_q;
    delay_d = delay_q;
    mode_d  = mode_q;

    if (in_ok) begin
      wp_d[in_ch] = cur_wp + 1'b1;
      if (cur_fill != '1) begin
        fill_d[in_ch] = cur_fill + 1'b1;
      end
    end
    // Config lands at the edge, so a same-cycle sample above still sees the old delay/mode.
    if (cfg_ok) begin
      delay_d[cfg_ch] = cfg_delay;
      mode_d[cfg_ch]  = mode_e'(cfg_mode);
    end
  end

  dp_ram #(
    .DEPTH (RAM_DEPTH),
    .AW    (RAM_AW),
    .DW    (D_WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (in_ok),
    .waddr ({in_ch, cur_wp}),
    .wdata (in_data),
    .raddr ({in_ch, rd_ptr}),
    .rdata (ram_rdata)
  );

  always_comb begin
    s1_valid_d  = in_ok;
    s1_ch_d     = in_ch;
    s1_data_d   = in_data;
    s1_mode_d   = cur_mode;
    s1_bypass_d = (cur_delay == '0);
    s1_prime_d  = (cur_fill < cur_delay);
  end

  always_comb begin
    if (s1_bypass_q) begin
      delayed = s1_data_q;
    end else if (s1_prime_q) begin
      delayed = '0;
    end else begin
      delayed = ram_rdata;
    end

    if (s1_mode_q == MODE_ECHO) begin
      mixed = D_WIDTH'(sat_add(int'(s1_data_q), int'(delayed >>> 1), D_WIDTH));
    end else begin
      mixed = delayed;
    end

    out_valid_d = s1_valid_q;
    out_ch_d    = s1_valid_q ? s1_ch_q : out_ch_q;
    out_data_d  = s1_valid_q ? mixed : out_data_q;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        wp_q[i]    <= '0;
        fill_q[i]  <= '0;
        delay_q[i] <= '0;
        mode_q[i]  <= MODE_DELAY;
      end
      s1_valid_q  <= 1'b0;
      s1_ch_q     <= '0;
      s1_data_q   <= '0;
      s1_mode_q   <= MODE_DELAY;
      s1_bypass_q <= 1'b0;
      s1_prime_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_data_q  <= '0;
    end else begin
      wp_q        <= wp_d;
      fill_q      <= fill_d;
      delay_q     <= delay_d;
      mode_q      <= mode_d;
      s1_valid_q  <= s1_valid_d;
      s1_ch_q     <= s1_ch_d;
      s1_data_q   <= s1_data_d;
      s1_mode_q   <= s1_mode_d;
      s1_bypass_q <= s1_bypass_d;
      s1_prime_q  <= s1_prime_d;
      out_valid_q <= out_valid_d;
      out_ch_q    <= out_ch_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_multi_ch_delay_line.sv
// Scoreboard bench for multi_ch_delay_line: a per-channel history model predicts each output.
module tb_multi_ch_delay_line;

  localparam int AW   = 3;
  localparam int DW   = 8;
  localparam int NCH  = 2;
  localparam int CHW  = 1;
  localparam int HMAX = 1024;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic           in_valid = 1'b0;
  logic [CHW-1:0] in_ch = '0;
  logic [DW-1:0]  in_data = '0;
  logic           cfg_we = 1'b0;
  logic [CHW-1:0] cfg_ch = '0;
  logic [AW-1:0]  cfg_delay = '0;
  logic           cfg_mode = 1'b0;
  logic           out_valid;
  logic [CHW-1:0] out_ch;
  logic [DW-1:0]  out_data;

  always #5 clk = ~clk;

  multi_ch_delay_line #(
    .ADDR_WIDTH (AW),
    .D_WIDTH    (DW),
    .NUM_CH     (NCH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ch     (in_ch),
    .in_data   (in_data),
    .cfg_we    (cfg_we),
    .cfg_ch    (cfg_ch),
    .cfg_delay (cfg_delay),
    .cfg_mode  (cfg_mode),
    .out_valid (out_valid),
    .out_ch    (out_ch),
    .out_data  (out_data)
  );

  typedef struct {
    logic [CHW-1:0] ch;
    logic [DW-1:0]  data;
    int             cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  // Reference model: full per-channel sample history plus the programmed delay/mode.
  int hist   [NCH][HMAX];
  int cnt    [NCH];
  int m_delay[NCH];
  int m_mode [NCH];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int c = 0; c < NCH; c++) begin
      cnt[c]     = 0;
      m_delay[c] = 0;
      m_mode[c]  = 0;
    end
  endtask

  function automatic logic [DW-1:0] model_out(input int c, input logic [DW-1:0] d);
    int din;
    int dl;
    int s;
    din = int'($signed(d));
    if (m_delay[c] == 0)          dl = din;
    else if (cnt[c] < m_delay[c]) dl = 0;
    else                          dl = hist[c][cnt[c] - m_delay[c]];
    if (m_mode[c] != 0) begin
      s = din + (dl >>> 1);
      if (s > 127)  s = 127;
      if (s < -128) s = -128;
    end else begin
      s = dl;
    end
    return DW'(s);
  endfunction

  task automatic step(input logic v, input logic [CHW-1:0] ch, input logic [DW-1:0] d,
                      input logic we, input logic [CHW-1:0] cch, input logic [AW-1:0] cdly,
                      input logic cmode);
    exp_t e;
    in_valid  = v;
    in_ch     = ch;
    in_data   = d;
    cfg_we    = we;
    cfg_ch    = cch;
    cfg_delay = cdly;
    cfg_mode  = cmode;
    if (v) begin
      e.ch   = ch;
      e.data = model_out(int'(ch), d);
      e.cyc  = cyc + 2;
      sb.push_back(e);
      if (cnt[ch] < HMAX) begin
        hist[ch][cnt[ch]] = int'($signed(d));
        cnt[ch]++;
      end
    end
    if (we) begin
      m_delay[cch] = int'(cdly);
      m_mode[cch]  = int'(cmode);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    cfg_we   = 1'b0;
  endtask

  task automatic sample(input logic [CHW-1:0] ch, input logic [DW-1:0] d);
    step(1'b1, ch, d, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic configure(input logic [CHW-1:0] ch, input logic [AW-1:0] dly, input logic mode);
    step(1'b0, '0, '0, 1'b1, ch, dly, mode);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
  endtask

  // Asynchronous reset: outputs must clear before any clock edge; in-flight samples are forgotten.
  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_ch", 32'(out_ch), 32'd0);
    sb.delete();
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_out", 32'(out_valid), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("out_ch", 32'(out_ch), 32'(e.ch));
        check("out_data", 32'(out_data), 32'(e.data));
        check("latency", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  initial begin
    model_clear();
    #2;
    apply_reset();

    // Pure delay of 3: 1..5 -> 0,0,0,1,2
    configure(1'b0, 3'd3, 1'b0);
    for (int i = 1; i <= 5; i++) sample(1'b0, DW'(i));
    idle(3);

    // Bypass, then a delay change in the same cycle as a sample
    configure(1'b0, 3'd0, 1'b0);
    sample(1'b0, 8'h12);
    step(1'b1, 1'b0, 8'h34, 1'b1, 1'b0, 3'd2, 1'b0);
    sample(1'b0, 8'h56);
    idle(3);

    // Reset with samples still in the pipeline
    sample(1'b0, 8'h77);
    sample(1'b1, 8'h66);
    apply_reset();

    // Interleaved channels: ch0 delay 2, ch1 delay 1
    configure(1'b0, 3'd2, 1'b0);
    configure(1'b1, 3'd1, 1'b0);
    sample(1'b0, 8'd10);
    sample(1'b1, 8'd20);
    sample(1'b0, 8'd11);
    sample(1'b1, 8'd21);
    sample(1'b0, 8'd12);
    sample(1'b1, 8'd22);
    idle(3);
    apply_reset();

    // Echo mix saturation, both rails
    configure(1'b0, 3'd1, 1'b1);
    sample(1'b0, 8'd100);
    sample(1'b0, 8'd100);
    sample(1'b0, 8'h80);
    sample(1'b0, 8'h80);
    idle(3);
    apply_reset();

    // Maximum delay with pointer wrap and fill saturation
    configure(1'b0, 3'd7, 1'b0);
    for (int i = 1; i <= 20; i++) sample(1'b0, DW'(i));
    idle(3);

    // Random traffic with occasional reconfiguration
    repeat (400) begin
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 8'($urandom),
           1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
           3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
    end

    for (int i = 0; i < 10 && sb.size() != 0; i++) idle(1);
    check("drain_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
